// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader and run/step execution controller for the MIPS core.
// Define INSTR_LOADER_CYCLE_CNT_EN to add the saturating CYCLE_COUNT output.
module instr_loader #(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter logic [WORD_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [BYTE_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    input  logic                  MODE_STEP,
    input  logic                  STEP_REQ,
    input  logic                  CPU_HALTED,
    output logic                  IMEM_WE,
    output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
    output logic [WORD_WIDTH-1:0] IMEM_WDATA,
    output logic                  CPU_EN,
    output logic                  LOAD_DONE,
    output logic [ADDR_WIDTH:0]   WORD_COUNT,
`ifdef INSTR_LOADER_CYCLE_CNT_EN
    output logic                  ERR_OVF,
    output logic [31:0]           CYCLE_COUNT
`else
    output logic                  ERR_OVF
`endif
);
    localparam int BPW = WORD_WIDTH / BYTE_WIDTH;
    localparam int CW = BPW > 1 ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {S_LOAD, S_RUN, S_STEP_IDLE, S_STEP_EXEC, S_HALTED, S_ERROR} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d, wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic                  rdy_q, rdy_d, we_q, we_d, done_q, done_d, ovf_q, ovf_d, step_q;
    logic                  xfer, last, step_rise;

    assign xfer      = RX_VALID && rdy_q;
    assign last      = xfer && cnt_q == CW'(BPW - 1);
    assign step_rise = STEP_REQ && !step_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (xfer) begin
            asm_d = WORD_WIDTH'({asm_q, RX_DATA});
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        // A completed word with memory already full is dropped, halt word included
        if (last) begin
            if (wc_q[ADDR_WIDTH]) begin
                ovf_d   = 1'b1;
                state_d = S_ERROR;
            end else begin
                we_d    = 1'b1;
                addr_d  = wc_q[ADDR_WIDTH-1:0];
                wdata_d = asm_d;
                wc_d    = wc_q + 1'b1;
                if (asm_d == HALT_WORD) begin
                    done_d  = 1'b1;
                    state_d = MODE_STEP ? S_STEP_IDLE : S_RUN;
                end
            end
        end
        case (state_q)
            S_RUN:       state_d = CPU_HALTED ? S_HALTED : S_RUN;
            S_STEP_IDLE: state_d = CPU_HALTED ? S_HALTED : step_rise ? S_STEP_EXEC : S_STEP_IDLE;
            S_STEP_EXEC: state_d = S_STEP_IDLE;
            default:     ;
        endcase
        rdy_d = state_d == S_LOAD;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            asm_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wc_q    <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            step_q  <= STEP_REQ;
        end
    end

    assign RX_READY   = rdy_q;
    assign IMEM_WE    = we_q;
    assign IMEM_ADDR  = addr_q;
    assign IMEM_WDATA = wdata_q;
    assign CPU_EN     = state_q == S_RUN || state_q == S_STEP_EXEC;
    assign LOAD_DONE  = done_q;
    assign WORD_COUNT = wc_q;
    assign ERR_OVF    = ovf_q;

`ifdef INSTR_LOADER_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge CLK) begin
        if (RESET) cyc_q <= '0;
        else       cyc_q <= cyc_q + {31'd0, CPU_EN && cyc_q != '1};
    end

    assign CYCLE_COUNT = cyc_q;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized scoreboard bench for instr_loader (ADDR_WIDTH=2, four-word memory).
module tb_instr_loader;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [7:0]    RX_DATA = '0;
    logic          RX_VALID = 1'b0;
    logic          MODE_STEP = 1'b0;
    logic          STEP_REQ = 1'b0;
    logic          CPU_HALTED = 1'b0;
    logic          RX_READY, IMEM_WE, CPU_EN, LOAD_DONE, ERR_OVF;
    logic [AW-1:0] IMEM_ADDR;
    logic [31:0]   IMEM_WDATA;
    logic [AW:0]   WORD_COUNT;
`ifdef INSTR_LOADER_CYCLE_CNT_EN
    logic [31:0]   CYCLE_COUNT;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_cyc = 0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  prog[$];
    bit          s[$];

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .MODE_STEP(MODE_STEP), .STEP_REQ(STEP_REQ), .CPU_HALTED(CPU_HALTED),
        .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA), .CPU_EN(CPU_EN),
        .LOAD_DONE(LOAD_DONE), .WORD_COUNT(WORD_COUNT),
`ifdef INSTR_LOADER_CYCLE_CNT_EN
        .CYCLE_COUNT(CYCLE_COUNT),
`endif
        .ERR_OVF(ERR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write
    always @(negedge CLK) begin
        if (IMEM_WE) begin
            if (exp_data.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_we: write addr %0d data %0h with none expected", IMEM_ADDR, IMEM_WDATA);
            end else begin
                chk("wr_addr", 64'(IMEM_ADDR), 64'(exp_addr.pop_front()));
                chk("wr_data", 64'(IMEM_WDATA), 64'(exp_data.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        RX_VALID = 1'b0;
        STEP_REQ = 1'b0;
        CPU_HALTED = 1'b0;
        exp_cyc = 0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_outputs", {RX_READY, IMEM_WE, CPU_EN, LOAD_DONE, ERR_OVF}, 5'b0);
        chk("rst_addr", 64'(IMEM_ADDR), 0);
        chk("rst_wdata", 64'(IMEM_WDATA), 0);
        chk("rst_word_count", 64'(WORD_COUNT), 0);
        tick();
        @(negedge CLK);
        chk("rx_ready_after_rst", 64'(RX_READY), 1);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) tick();
        RX_DATA = b;
        RX_VALID = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!RX_READY && n < 50);
        chk("rx_accept", 64'(RX_READY), 1);
        tick();
        RX_VALID = 1'b0;
    endtask

    // Reference model: words are big-endian byte groups; each is written in order until a
    // halt word (written) or a word arriving with the memory full (dropped, overflow).
    task automatic load_prog(input int gmax, output bit done, output bit ovf, output int wc);
        logic [31:0] w;
        done = 0;
        ovf = 0;
        wc = 0;
        for (int i = 0; i < prog.size(); i++) begin
            if (i % 4 == 3) begin
                w = {prog[i-3], prog[i-2], prog[i-1], prog[i]};
                if (wc == DEPTH) ovf = 1;
                else begin
                    exp_addr.push_back(wc);
                    exp_data.push_back(w);
                    wc++;
                    done = (w == 32'hFFFFFFFF);
                end
            end
            send_byte(prog[i], $urandom_range(gmax, 0));
            if (done || ovf) break;
        end
    endtask

    task automatic run_exec(input int h);
        for (int i = 0; i < h; i++) begin
            if (i == h - 1) CPU_HALTED = 1'b1;
            @(negedge CLK);
            chk("run_en", 64'(CPU_EN), 1);
            tick();
        end
        exp_cyc += h;
        CPU_HALTED = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("halted_en", 64'(CPU_EN), 0);
            tick();
        end
    endtask

    // CPU_EN in cycle t is high exactly when STEP_REQ rose between samples t-2 and t-1
    task automatic step_exec(input int nrand);
        bit e;
        s = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        repeat (nrand) s.push_back(1'($urandom));
        for (int t = 0; t <= s.size(); t++) begin
            STEP_REQ = t < s.size() ? s[t] : 1'b0;
            e = t >= 1 && s[t-1] && !(t >= 2 && s[t-2]);
            @(negedge CLK);
            chk("step_en", 64'(CPU_EN), 64'(e));
            if (e) exp_cyc++;
            tick();
        end
        tick();
        CPU_HALTED = 1'b1;
        STEP_REQ = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("halt_vs_step_en", 64'(CPU_EN), 0);
            tick();
        end
        CPU_HALTED = 1'b0;
        STEP_REQ = 1'b0;
        tick();
        STEP_REQ = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("halted_step_en", 64'(CPU_EN), 0);
            tick();
        end
        STEP_REQ = 1'b0;
    endtask

    task automatic idle_exec();
        repeat (5) begin
            STEP_REQ = ~STEP_REQ;
            @(negedge CLK);
            chk("idle_en", 64'(CPU_EN), 0);
            tick();
        end
        STEP_REQ = 1'b0;
    endtask

    task automatic exec(input bit mode, input bit done, input bit ovf);
        if (ovf || !done) idle_exec();
        else if (mode) step_exec($urandom_range(20, 5));
        else run_exec($urandom_range(15, 1));
    endtask

    task automatic status(input bit done, input bit ovf, input int wc);
        @(negedge CLK);
        chk("load_done", 64'(LOAD_DONE), 64'(done));
        chk("err_ovf", 64'(ERR_OVF), 64'(ovf));
        chk("word_count", 64'(WORD_COUNT), 64'(wc));
        chk("rx_ready_end", 64'(RX_READY), 0);
        chk("sb_drained", 64'(exp_data.size()), 0);
`ifdef INSTR_LOADER_CYCLE_CNT_EN
        chk("cycle_count", 64'(CYCLE_COUNT), 64'(exp_cyc));
`endif
        tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) prog.push_back(w[k*8 +: 8]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        return w == 32'hFFFFFFFF ? 32'h7FFFFFFF : w;
    endfunction

    initial begin
        bit done, ovf, mode;
        int wc, n, hpos;
        // Fixed program, back-to-back, continuous run halted 10 cycles after load
        do_reset();
        MODE_STEP = 1'b0;
        prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load_prog(0, done, ovf, wc);
        MODE_STEP = 1'b1;
        run_exec(10);
        status(done, ovf, wc);
        // Same program with idle gaps, step mode
        do_reset();
        MODE_STEP = 1'b1;
        load_prog(3, done, ovf, wc);
        MODE_STEP = 1'b0;
        step_exec(12);
        status(done, ovf, wc);
        // Five non-halt words overflow a four-word memory
        do_reset();
        MODE_STEP = 1'b0;
        prog.delete();
        repeat (5) push_word(rand_word());
        load_prog(2, done, ovf, wc);
        idle_exec();
        status(done, ovf, wc);
        // Reset after a partial word discards it
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        do_reset();
        mode = 1'($urandom);
        MODE_STEP = mode;
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load_prog(1, done, ovf, wc);
        exec(mode, done, ovf);
        status(done, ovf, wc);
        // Random programs: halt anywhere, possibly past the end of memory
        repeat (8) begin
            do_reset();
            mode = 1'($urandom);
            MODE_STEP = mode;
            n = $urandom_range(6, 1);
            hpos = $urandom_range(n, 0);
            prog.delete();
            for (int i = 0; i < n; i++) push_word(i == hpos ? 32'hFFFFFFFF : rand_word());
            if (hpos == n && n <= DEPTH) push_word(32'hFFFFFFFF);
            load_prog(2, done, ovf, wc);
            MODE_STEP = ~mode;
            exec(mode, done, ovf);
            status(done, ovf, wc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end
endmodule
